// File: rtl/salsa_core_scheduler_pkg.sv
// rtl/salsa_core_scheduler_pkg.sv - shared types and constants for the Salsa20/8 core scheduler
package salsa_core_scheduler_pkg;

  localparam int BLOCK_W         = 512;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_DELIVER
  } state_t;

  // Round-robin pointer advance: the index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/salsa_core_scheduler_rr_arbiter.sv
// rtl/salsa_core_scheduler_rr_arbiter.sv - round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  always_comb begin
    int cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/salsa_core_scheduler.sv
// rtl/salsa_core_scheduler.sv - shares one Salsa20/8 core between NUM_REQ requesters, round-robin
module salsa_core_scheduler
  import salsa_core_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [BLOCK_W-1:0]         rsp_data,
  output logic                       core_start,
  output logic [BLOCK_W-1:0]         core_in,
  input  logic                       core_done,
  input  logic [BLOCK_W-1:0]         core_out,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [BLOCK_W-1:0] sel_data;
  logic [IDX_W-1:0]   next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // One-hot grant mux over constant slices keeps the data path free of variable part-selects.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_data = req_data[i*BLOCK_W +: BLOCK_W];
    end
  end

  assign next_ptr = IDX_W'(wrap_inc(int'(grant_idx), NUM_REQ));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      grant_oh    <= '0;
      wait_cnt    <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      core_start  <= 1'b0;
      core_in     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_idx  <= arb_idx;
            grant_oh   <= arb_grant;
            core_in    <= sel_data;
            req_ready  <= arb_grant;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wait_cnt <= '0;
          state    <= ST_BUSY;
        end
        ST_BUSY: begin
          // A done arriving on the expiry cycle still delivers its result.
          if (core_done) begin
            rsp_data  <= core_out;
            rsp_valid <= grant_oh;
            state     <= ST_DELIVER;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DELIVER: begin
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_salsa_core_scheduler.sv
// tb/tb_salsa_core_scheduler.sv - self-checking bench for salsa_core_scheduler
module tb_salsa_core_scheduler;

  localparam int N       = 4;
  localparam int TIMEOUT = 255;
  localparam int BW      = 512;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*BW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [BW-1:0]   rsp_data;
  logic            core_start;
  logic [BW-1:0]   core_in;
  logic            core_done;
  logic [BW-1:0]   core_out;
  logic            busy;
  logic            timeout_err;

  int vectors     = 0;
  int miscompares = 0;

  salsa_core_scheduler #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .core_start  (core_start),
    .core_in     (core_in),
    .core_done   (core_done),
    .core_out    (core_out),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Stand-in core: a fixed word-wise permutation, so the expected result is computable from the request.
  function automatic logic [BW-1:0] core_fn(input logic [BW-1:0] x);
    logic [BW-1:0] y;
    logic [31:0]   w;
    for (int i = 0; i < 16; i++) begin
      w = x[i*32 +: 32];
      y[i*32 +: 32] = {w[22:0], w[31:23]} ^ (32'h9e3779b9 * 32'(i + 1));
    end
    return y;
  endfunction

  assign core_out = core_fn(core_in);

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"},   req_ready,   0);
    check({tag, "_rsp_valid"},   rsp_valid,   0);
    check({tag, "_core_start"},  core_start,  0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_core_in"},     core_in,     0);
    check({tag, "_rsp_data"},    rsp_data,    0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    core_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one job from an IDLE negedge: grant latency, core handshake, response timing and data.
  task automatic do_job(input int exp_g, input int lat, input bit refill);
    logic [BW-1:0] blk;
    int            k;
    bit            seen;
    blk = req_data[exp_g*BW +: BW];
    k = 0;
    while (req_ready == '0 && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("ready_latency", k, 1);
    check("ready_grant", req_ready, BW'(1) << exp_g);
    check("core_start", core_start, 1);
    check("core_in", core_in, blk);
    req_valid[exp_g] = refill;
    if (refill) req_data[exp_g*BW +: BW] = rand_block();
    k    = 0;
    seen = 1'b0;
    while (!seen && k < lat + 40) begin
      @(negedge clk);
      k++;
      core_done = (k == lat + 1);
      if (k == 1) check("start_pulse", core_start, 0);
      if (req_ready != '0) check("no_ready_while_busy", req_ready, 0);
      if (rsp_valid != '0) seen = 1'b1;
    end
    core_done = 1'b0;
    check("rsp_latency", k, lat + 2);
    check("rsp_index", rsp_valid, BW'(1) << exp_g);
    check("rsp_ready_excl", req_ready, 0);
    check("rsp_data", rsp_data, core_fn(blk));
    @(negedge clk);
    check("rsp_pulse", rsp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           lat;
    int           exp_g;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int            k;
    bit            seen;
    bit            pending[N];
    int            mptr;
    int            g;
    logic [BW-1:0] saved;

    // Expected grants follow the pointer from reset: 0 -> 3 -> 0 -> 1 -> 1 -> 2 -> 1 -> 0 -> 2.
    vecs[0] = '{4'b0100, 10, 2};
    vecs[1] = '{4'b1001,  4, 3};
    vecs[2] = '{4'b1001,  0, 0};
    vecs[3] = '{4'b0001,  7, 0};
    vecs[4] = '{4'b1110,  2, 1};
    vecs[5] = '{4'b0011,  5, 0};
    vecs[6] = '{4'b1000,  3, 3};
    vecs[7] = '{4'b0110,  1, 1};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    core_done = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // All requesters continuously requesting.
    for (int i = 0; i < N; i++) req_data[i*BW +: BW] = rand_block();
    req_valid = '1;
    for (int j = 0; j < 5; j++) do_job(j % N, $urandom_range(0, 6), 1'b1);
    req_valid = '0;

    do_reset();
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) req_data[i*BW +: BW] = rand_block();
      if (v == 0) req_data[2*BW +: BW] = {4{128'hae042d63_c3823f85_2d0a38cd_7af25f75}};
      req_valid = vecs[v].mask;
      do_job(vecs[v].exp_g, vecs[v].lat, 1'b0);
      req_valid = '0;
    end

    // Spurious done while idle.
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("spurious_busy", busy, 0);
      check("spurious_rsp", rsp_valid, 0);
    end

    // Core never completes.
    req_data[1*BW +: BW] = rand_block();
    req_valid = 4'b0010;
    k = 0;
    while (req_ready == '0 && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("to_ready_grant", req_ready, 4'b0010);
    req_valid = '0;
    k    = 0;
    seen = 1'b0;
    while (!timeout_err && k < TIMEOUT + 20) begin
      @(negedge clk);
      k++;
      if (rsp_valid != '0) seen = 1'b1;
      if (k == TIMEOUT) check("to_busy_before", busy, 1);
    end
    check("to_cycles", k, TIMEOUT + 1);
    check("to_busy_after", busy, 0);
    check("to_no_rsp", seen, 0);
    req_data[0*BW +: BW] = rand_block();
    req_valid = 4'b0001;
    do_job(0, 6, 1'b0);
    req_valid = '0;
    check("to_sticky", timeout_err, 1);

    // Reset while busy, with a late done afterwards.
    req_data[2*BW +: BW] = rand_block();
    req_valid = 4'b0100;
    k = 0;
    while (req_ready == '0 && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("rst_ready_grant", req_ready, 4'b0100);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midrst");
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    check("midrst_quiet", seen, 0);
    for (int i = 0; i < N; i++) req_data[i*BW +: BW] = rand_block();
    req_valid = 4'b1001;
    do_job(0, 3, 1'b0);
    req_valid = '0;

    // Randomized traffic against a pending-set model with a round-robin pointer.
    mptr = 1;
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    for (int j = 0; j < 30; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          req_data[i*BW +: BW] = rand_block();
        end
      end
      if (!(pending[0] || pending[1] || pending[2] || pending[3])) begin
        g = $urandom_range(0, N - 1);
        pending[g] = 1'b1;
        req_data[g*BW +: BW] = rand_block();
      end
      for (int i = 0; i < N; i++) req_valid[i] = pending[i];
      g = -1;
      for (int s = 0; s < N; s++) begin
        if (g < 0 && pending[(mptr + s) % N]) g = (mptr + s) % N;
      end
      saved = req_data[g*BW +: BW];
      do_job(g, $urandom_range(0, 20), 1'b0);
      check("rand_data_held", req_data[g*BW +: BW], saved);
      pending[g] = 1'b0;
      mptr = (g + 1) % N;
    end
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
